fetch_unit: RTL

Instruction fetch stage directly downstream of the PC. Issues one instruction-memory read per instruction using a req/ack handshake. Captures the 21-bit instruction into an instruction register and offers it to decode over valid/ready. Pulses PC_Inc on each completed fetch and flushes in-flight fetches on a branch redirect.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int ADDR_WIDTH  = 16;
   localparam int INSTR_WIDTH = 21;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'd0,
      FS_REQ     = 2'd1,
      FS_HOLD    = 2'd2,
      FS_DISCARD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: PC link, redirect, instruction-memory req/ack and IR valid/ready.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH  = fetch_unit_pkg::ADDR_WIDTH,
   parameter int INSTR_WIDTH = fetch_unit_pkg::INSTR_WIDTH
);

   logic                   Fetch_En;
   logic [ADDR_WIDTH-1:0]  PC_Out;
   logic                   PC_Inc;
   logic                   Redirect;
   logic [ADDR_WIDTH-1:0]  Redirect_Addr;
   logic                   Mem_Req;
   logic [ADDR_WIDTH-1:0]  Mem_Addr;
   logic                   Mem_Ack;
   logic [INSTR_WIDTH-1:0] Mem_Data;
   logic [INSTR_WIDTH-1:0] IR_Out;
   logic [ADDR_WIDTH-1:0]  IR_PC;
   logic                   IR_Valid;
   logic                   IR_Ready;

   modport master (
      input  Fetch_En, PC_Out, Redirect, Redirect_Addr, Mem_Ack, Mem_Data, IR_Ready,
      output PC_Inc, Mem_Req, Mem_Addr, IR_Out, IR_PC, IR_Valid
   );

   modport slave (
      output Fetch_En, PC_Out, Redirect, Redirect_Addr, Mem_Ack, Mem_Data, IR_Ready,
      input  PC_Inc, Mem_Req, Mem_Addr, IR_Out, IR_PC, IR_Valid
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one req/ack memory read per instruction, captured into IR
// and offered to decode over valid/ready; branch redirects flush in-flight fetches.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = fetch_unit_pkg::ADDR_WIDTH,
   parameter int INSTR_WIDTH = fetch_unit_pkg::INSTR_WIDTH
) (
   input  logic         Clk,
   input  logic         Rst_n,
   fetch_unit_if.master bus
);

   fetch_state_t           r_state;
   logic                   r_mem_req;
   logic [ADDR_WIDTH-1:0]  r_fetch_addr;
   logic [ADDR_WIDTH-1:0]  r_req_addr;
   logic [INSTR_WIDTH-1:0] r_ir_out;
   logic [ADDR_WIDTH-1:0]  r_ir_pc;
   logic                   r_ir_valid;

   logic                   w_capture;
   logic [ADDR_WIDTH-1:0]  w_fetch_inc;
   logic [ADDR_WIDTH-1:0]  w_resume_addr;

   // NOTE: PC_Inc is combinational so the PC advances on the same edge that captures the word.
   assign w_capture     = (r_state == FS_REQ) && bus.Mem_Ack && !bus.Redirect;
   assign w_fetch_inc   = r_fetch_addr + ADDR_WIDTH'(1);
   assign w_resume_addr = bus.Redirect ? bus.Redirect_Addr : r_fetch_addr;

   assign bus.PC_Inc   = w_capture;
   assign bus.Mem_Req  = r_mem_req;
   assign bus.Mem_Addr = r_req_addr;
   assign bus.IR_Out   = r_ir_out;
   assign bus.IR_PC    = r_ir_pc;
   assign bus.IR_Valid = r_ir_valid;

   // NOTE: all state here is sequential, so every assignment below is non-blocking.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state      <= FS_IDLE;
         r_mem_req    <= 1'b0;
         r_fetch_addr <= '0;
         r_req_addr   <= '0;
         r_ir_out     <= '0;
         r_ir_pc      <= '0;
         r_ir_valid   <= 1'b0;
      end else begin
         case (r_state)
            FS_IDLE: begin
               if (bus.Redirect) begin
                  r_fetch_addr <= bus.Redirect_Addr;
                  if (bus.Fetch_En) begin
                     r_req_addr <= bus.Redirect_Addr;
                     r_mem_req  <= 1'b1;
                     r_state    <= FS_REQ;
                  end
               end else if (bus.Fetch_En) begin
                  r_fetch_addr <= bus.PC_Out;
                  r_req_addr   <= bus.PC_Out;
                  r_mem_req    <= 1'b1;
                  r_state      <= FS_REQ;
               end
            end

            FS_REQ: begin
               if (bus.Redirect) begin
                  r_fetch_addr <= bus.Redirect_Addr;
                  // A coincident ack closes the transaction, so reissue straight away.
                  if (bus.Mem_Ack) r_req_addr <= bus.Redirect_Addr;
                  else             r_state    <= FS_DISCARD;
               end else if (bus.Mem_Ack) begin
                  r_ir_out     <= bus.Mem_Data;
                  r_ir_pc      <= r_req_addr;
                  r_ir_valid   <= 1'b1;
                  r_fetch_addr <= w_fetch_inc;
                  r_mem_req    <= 1'b0;
                  r_state      <= FS_HOLD;
               end
            end

            FS_HOLD: begin
               if (bus.Redirect) begin
                  r_fetch_addr <= bus.Redirect_Addr;
                  r_req_addr   <= bus.Redirect_Addr;
                  r_ir_valid   <= 1'b0;
                  r_mem_req    <= 1'b1;
                  r_state      <= FS_REQ;
               end else if (bus.IR_Ready) begin
                  r_ir_valid <= 1'b0;
                  if (bus.Fetch_En) begin
                     r_req_addr <= r_fetch_addr;
                     r_mem_req  <= 1'b1;
                     r_state    <= FS_REQ;
                  end else begin
                     r_state <= FS_IDLE;
                  end
               end
            end

            FS_DISCARD: begin
               if (bus.Redirect) r_fetch_addr <= bus.Redirect_Addr;
               // The stale word is dropped; the old address stays on the bus until its ack.
               if (bus.Mem_Ack) begin
                  r_req_addr <= w_resume_addr;
                  if (bus.Fetch_En) begin
                     r_state <= FS_REQ;
                  end else begin
                     r_mem_req <= 1'b0;
                     r_state   <= FS_IDLE;
                  end
               end
            end

            default: begin
               r_mem_req <= 1'b0;
               r_state   <= FS_IDLE;
            end
         endcase
      end
   end

endmodule
